data_memory_responder: RTL and testbench

Data-side memory responder for the RV32I core: the slave that answers the load/store requests driven by the memory-access stage. It decodes address, size and read/write strobes and performs byte/half/word stores into a word-organised RAM with per-byte lane enables. Loads return the addressed lane right-aligned and zero-filled; the memory-access stage performs sign/zero extension. A configurable wait-state counter with a ready handshake lets the same block model slow memory.

---
 rtl/data_memory_responder_pkg.sv | 32 +++
 rtl/data_memory_responder_data_ram.sv | 26 ++
 rtl/data_memory_responder.sv | 131 +++++++++++++
 tb/tb_data_memory_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared access-size encodings, FSM state type and lane helpers for the
// data-side memory responder.
package data_memory_responder_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {IDLE, WAIT} state_t;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: return 4'b0001 << lane;
         SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         default:   return 4'b1111;
      endcase
   endfunction

   // Right-align the addressed lane of a RAM word and zero-fill above it.
   function automatic logic [31:0] lane_align(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SIZE_BYTE: return {24'b0, sh[7:0]};
         SIZE_HALF: return {16'b0, sh[15:0]};
         default:   return word;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_responder_data_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module data_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data-side load/store responder: decode, lane alignment, error checks and an
// optional wait-state FSM in front of a byte-enabled word RAM.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clk_en,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_wr,
   input  logic [1:0]  i_data_rd_en_ctrl,
   input  logic        i_data_rd_en_ma,
   input  logic        i_data_wr_en_ma,
   output logic [31:0] o_data_rd,
   output logic        o_data_ready,
   output logic        o_data_err
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        req, misaligned, in_range, bad;
   logic        done, ld_ok, st_ok, err_done;
   logic [1:0]  lane;
   logic [3:0]  be;
   logic [31:0] wdata, rdata;
   logic        rd_zero;
   logic [1:0]  ld_size, ld_lane;

   assign req      = i_data_rd_en_ma | i_data_wr_en_ma;
   assign lane     = i_data_addr[1:0];
   assign in_range = (i_data_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

   always_comb begin
      misaligned = 1'b0;
      case (i_data_rd_en_ctrl)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = lane[0];
         SIZE_WORD: misaligned = (lane != 2'b00);
         default:   misaligned = 1'b1;
      endcase
   end

   assign bad = misaligned | ~in_range | (i_data_rd_en_ma & i_data_wr_en_ma);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else if (i_clk_en) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req && WAIT_STATES > 0) begin
               cnt_nxt   = WS_LOAD;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_data_ready = (WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);

   // A strobe-less completing edge (requester dropped out mid-WAIT) does nothing.
   assign done     = i_clk_en & o_data_ready & req;
   assign ld_ok    = done & i_data_rd_en_ma & ~bad;
   assign st_ok    = done & i_data_wr_en_ma & ~bad;
   assign err_done = done & bad;

   assign be = lane_be(i_data_rd_en_ctrl, lane);

   always_comb begin
      wdata = i_data_wr;
      case (i_data_rd_en_ctrl)
         SIZE_BYTE: wdata = {4{i_data_wr[7:0]}};
         SIZE_HALF: wdata = {2{i_data_wr[15:0]}};
         default:   wdata = i_data_wr;
      endcase
   end

   data_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk   (i_clk),
      .we    (st_ok),
      .be    (be),
      .re    (ld_ok),
      .addr  (i_data_addr[AW+1:2]),
      .wdata (wdata),
      .rdata (rdata)
   );

   // RAM read register only moves on a good load; rd_zero masks it after
   // reset or an errored access so o_data_rd reads 0 until the next load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data_err <= 1'b0;
         rd_zero    <= 1'b1;
         ld_size    <= SIZE_WORD;
         ld_lane    <= 2'b00;
      end else if (i_clk_en) begin
         o_data_err <= err_done;
         if (err_done) begin
            rd_zero <= 1'b1;
         end else if (ld_ok) begin
            rd_zero <= 1'b0;
            ld_size <= i_data_rd_en_ctrl;
            ld_lane <= lane;
         end
      end
   end

   assign o_data_rd = rd_zero ? 32'd0 : lane_align(rdata, ld_size, ld_lane);

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: one zero-wait instance and one
// two-wait-state instance checked against a byte-array reference model.
module tb_data_memory_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0_n, en0, rde0, wre0, rdy0, err0;
   logic [1:0]  sz0;
   logic [31:0] a0, d0, q0;
   logic        rst2_n, en2, rde2, wre2, rdy2, err2;
   logic [1:0]  sz2;
   logic [31:0] a2, d2, q2;

   data_memory_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst0_n), .i_clk_en(en0), .i_data_addr(a0), .i_data_wr(d0),
      .i_data_rd_en_ctrl(sz0), .i_data_rd_en_ma(rde0), .i_data_wr_en_ma(wre0),
      .o_data_rd(q0), .o_data_ready(rdy0), .o_data_err(err0));

   data_memory_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst2_n), .i_clk_en(en2), .i_data_addr(a2), .i_data_wr(d2),
      .i_data_rd_en_ctrl(sz2), .i_data_rd_en_ma(rde2), .i_data_wr_en_ma(wre2),
      .o_data_rd(q2), .o_data_ready(rdy2), .o_data_err(err2));

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem  [2][256];
   logic [31:0] last [2];
   logic [31:0] base [2] = '{32'h0000_0000, 32'h0000_1000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Byte-addressed memory view: stores write n bytes, loads gather n bytes.
   task automatic model(input int w, input logic r, input logic wv, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic e, output logic [31:0] q);
      int n;
      logic [31:0] off;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = a - base[w];
      e   = 1'b0;
      if (r || wv) begin
         e = (r && wv) || (sz == 2'd3) || ((a % n) != 0) || (off >= 256);
         if (e) last[w] = 32'd0;
         else if (wv) begin
            for (int k = 0; k < n; k++) mem[w][off + k] = d[8*k +: 8];
         end else begin
            q = 32'd0;
            for (int k = 0; k < n; k++) q[8*k +: 8] = mem[w][off + k];
            last[w] = q;
         end
      end
      q = last[w];
   endtask

   task automatic acc0(input logic r, input logic wv, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
      logic e;
      logic [31:0] q;
      rde0 = r; wre0 = wv; sz0 = sz; a0 = a; d0 = d;
      @(posedge clk);
      @(negedge clk);
      model(0, r, wv, sz, a, d, e, q);
      chk("err0", {31'b0, err0}, {31'b0, e});
      chk("rd0", q0, q);
   endtask

   task automatic acc2(input logic r, input logic wv, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input int stall_at);
      logic e;
      logic [31:0] q;
      int cyc;
      rde2 = r; wre2 = wv; sz2 = sz; a2 = a; d2 = d;
      cyc = 0;
      while (!rdy2 && cyc < 20) begin
         chk("hold2", q2, last[1]);
         en2 = (cyc != stall_at);
         @(negedge clk);
         cyc++;
      end
      en2 = 1'b1;
      chk("wait_cyc", 32'(cyc), (stall_at == 0 || stall_at == 1) ? 32'd3 : 32'd2);
      @(posedge clk);
      @(negedge clk);
      model(1, r, wv, sz, a, d, e, q);
      chk("err2", {31'b0, err2}, {31'b0, e});
      chk("rd2", q2, q);
      chk("rdy2_idle", {31'b0, rdy2}, 32'd0);
      rde2 = 1'b0; wre2 = 1'b0;
   endtask

   task automatic rand_op(output logic r, output logic wv, output logic [1:0] sz,
                          input logic allow_idle);
      int k;
      k  = allow_idle ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 8));
      r  = (k <= 4);
      wv = (k == 0) || (k >= 5 && k <= 8);
      k  = int'($urandom_range(0, 7));
      sz = (k == 7) ? 2'd3 : 2'(k % 3);
   endtask

   initial begin
      logic r, wv;
      logic [1:0] sz;
      logic [31:0] a;
      rst0_n = 1'b0; rst2_n = 1'b0; en0 = 1'b1; en2 = 1'b1;
      rde0 = 1'b0; wre0 = 1'b0; sz0 = 2'd0; a0 = 32'd0; d0 = 32'd0;
      rde2 = 1'b0; wre2 = 1'b0; sz2 = 2'd0; a2 = 32'd0; d2 = 32'd0;
      last[0] = 32'd0; last[1] = 32'd0;
      @(negedge clk); @(negedge clk);
      chk("rst_rd0", q0, 32'd0);
      chk("rst_err0", {31'b0, err0}, 32'd0);
      chk("rst_rdy0", {31'b0, rdy0}, 32'd1);
      chk("rst_rd2", q2, 32'd0);
      chk("rst_err2", {31'b0, err2}, 32'd0);
      chk("rst_rdy2", {31'b0, rdy2}, 32'd0);
      rst0_n = 1'b1; rst2_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 64; i++) acc0(1'b0, 1'b1, 2'd2, 32'(i * 4), $urandom);
      for (int i = 0; i < 64; i++) acc2(1'b0, 1'b1, 2'd2, base[1] + 32'(i * 4), $urandom, -1);

      acc0(1'b0, 1'b1, 2'd2, 32'h10, 32'hCAFEBABE);
      acc0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
      chk("d_word", q0, 32'hCAFEBABE);
      acc0(1'b0, 1'b1, 2'd0, 32'h13, 32'h1234_56AB);
      acc0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
      chk("d_byte_st", q0, 32'hABFEBABE);
      acc0(1'b1, 1'b0, 2'd1, 32'h12, 32'd0);
      chk("d_half_ld", q0, 32'h0000ABFE);
      acc0(1'b1, 1'b0, 2'd0, 32'h11, 32'd0);
      chk("d_byte_ld", q0, 32'h000000BA);
      acc0(1'b1, 1'b0, 2'd2, 32'h12, 32'd0);
      chk("d_mis_err", {31'b0, err0}, 32'd1);
      chk("d_mis_rd", q0, 32'd0);
      acc0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      chk("d_err_clr", {31'b0, err0}, 32'd0);
      acc0(1'b0, 1'b1, 2'd1, 32'h11, 32'h0000FFFF);
      acc0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
      chk("d_mis_nowr", q0, 32'hABFEBABE);
      acc0(1'b1, 1'b0, 2'd3, 32'h10, 32'd0);
      acc0(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
      chk("d_oor_err", {31'b0, err0}, 32'd1);
      acc0(1'b1, 1'b1, 2'd2, 32'h10, 32'd0);
      acc0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
      chk("d_both_nowr", q0, 32'hABFEBABE);

      for (int i = 0; i < 300; i++) begin
         rand_op(r, wv, sz, 1'b1);
         a = 32'($urandom_range(0, 32'h11F));
         if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
         acc0(r, wv, sz, a, $urandom);
      end

      acc2(1'b0, 1'b1, 2'd2, base[1] + 32'h10, 32'h1122_3344, -1);
      acc2(1'b1, 1'b0, 2'd2, base[1] + 32'h10, 32'd0, -1);
      chk("w_word", q2, 32'h1122_3344);
      acc2(1'b1, 1'b0, 2'd0, base[1] + 32'h13, 32'd0, 1);
      chk("w_stall_byte", q2, 32'h0000_0011);

      wre2 = 1'b1; sz2 = 2'd2; a2 = base[1] + 32'h20; d2 = 32'hDEAD_BEEF;
      @(negedge clk);
      rst2_n = 1'b0;
      #1;
      chk("mid_rst_rd", q2, 32'd0);
      chk("mid_rst_err", {31'b0, err2}, 32'd0);
      chk("mid_rst_rdy", {31'b0, rdy2}, 32'd0);
      wre2 = 1'b0;
      @(negedge clk);
      rst2_n = 1'b1;
      last[1] = 32'd0;
      @(negedge clk);
      chk("post_rst_idle", {31'b0, rdy2}, 32'd0);
      acc2(1'b1, 1'b0, 2'd2, base[1] + 32'h20, 32'd0, -1);

      for (int i = 0; i < 40; i++) begin
         rand_op(r, wv, sz, 1'b0);
         a = base[1] - 32'h20 + 32'($urandom_range(0, 32'h13F));
         if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
         acc2(r, wv, sz, a, $urandom, int'($urandom_range(0, 3)) - 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
